// File: rtl/vga_pkg.sv
// Shared VGA constants and the ball controller state type.
// Imported by draw_ball and ball_ctl.
package vga_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        PAUSE
    } ball_state_t;

endpackage

// File: rtl/ball_ctl.sv
// Ball controller: frame tick detect, serve/move/pause FSM,
// position and velocity registers, pause counter, goal pulses.
// Ports: clk, rst (sync, active-high), vblnk_in, start in;
//        ball_x, ball_y (top-left), goal_left, goal_right out.
// Optional macro BALL_ACCEL_EN: speed grows on each wall bounce.
module ball_ctl
    import vga_pkg::*;
#(
    parameter int BALL_SIZE    = 16,
    parameter int SPEED        = 4,
    parameter int MAX_SPEED    = 8,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic        start,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic        goal_left,
    output logic        goal_right
);

    localparam logic [10:0] X_C =
        11'(HOR_PIXELS / 2 - BALL_SIZE / 2);
    localparam logic [10:0] Y_C =
        11'(VER_PIXELS / 2 - BALL_SIZE / 2);
    localparam logic signed [11:0] X_MAX =
        12'(HOR_PIXELS - BALL_SIZE);
    localparam logic signed [11:0] Y_MAX =
        12'(VER_PIXELS - BALL_SIZE);
    localparam logic [10:0] Y_LIM =
        11'(VER_PIXELS - BALL_SIZE);
    localparam logic [10:0] SPD0  = 11'(SPEED);
    localparam logic [7:0]  P_LIM = 8'(PAUSE_FRAMES);

    if (PAUSE_FRAMES > 255 || MAX_SPEED < SPEED) begin : g_bad_cfg
        $error("ball_ctl: invalid parameter set");
    end

    ball_state_t state, state_n;
    logic [10:0] x, x_n, y, y_n;
    logic        dx_neg, dx_neg_n;
    logic        dy_neg, dy_neg_n;
    logic [7:0]  cnt, cnt_n;
    logic        start_q, start_n;
    logic        vb_q;
    logic        tick;
    logic        gl_n, gr_n;
    logic [10:0] spd;
    logic signed [11:0] vx, vy, xs, ys;

`ifdef BALL_ACCEL_EN
    localparam logic [10:0] SPD_MAX = 11'(MAX_SPEED);
    logic [10:0] spd_q, spd_n;
    assign spd = spd_q;
`else
    assign spd = SPD0;
`endif

    // Rising edge of vertical blanking marks one frame.
    assign tick = vblnk_in & ~vb_q;

    assign vx = dx_neg ? -$signed({1'b0, spd})
                       :  $signed({1'b0, spd});
    assign vy = dy_neg ? -$signed({1'b0, spd})
                       :  $signed({1'b0, spd});
    assign xs = $signed({1'b0, x}) + vx;
    assign ys = $signed({1'b0, y}) + vy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x          <= X_C;
            y          <= Y_C;
            dx_neg     <= 1'b0;
            dy_neg     <= 1'b0;
            cnt        <= 8'd0;
            start_q    <= 1'b0;
            vb_q       <= 1'b0;
            goal_left  <= 1'b0;
            goal_right <= 1'b0;
`ifdef BALL_ACCEL_EN
            spd_q      <= SPD0;
`endif
        end else begin
            state      <= state_n;
            x          <= x_n;
            y          <= y_n;
            dx_neg     <= dx_neg_n;
            dy_neg     <= dy_neg_n;
            cnt        <= cnt_n;
            start_q    <= start_n;
            vb_q       <= vblnk_in;
            goal_left  <= gl_n;
            goal_right <= gr_n;
`ifdef BALL_ACCEL_EN
            spd_q      <= spd_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        x_n      = x;
        y_n      = y;
        dx_neg_n = dx_neg;
        dy_neg_n = dy_neg;
        cnt_n    = cnt;
        start_n  = start_q;
        gl_n     = 1'b0;
        gr_n     = 1'b0;
`ifdef BALL_ACCEL_EN
        spd_n    = spd_q;
`endif
        if (state == IDLE && start) begin
            start_n = 1'b1;
        end
        if (tick) begin
            unique case (state)
                IDLE: begin
                    // Serve tick only arms motion.
                    if (start_q) begin
                        state_n = MOVE;
                        start_n = 1'b0;
                    end
                end
                MOVE: begin
                    // dx_neg is loaded here with the
                    // direction of the next serve.
                    if (xs[11]) begin
                        gl_n     = 1'b1;
                        state_n  = PAUSE;
                        x_n      = X_C;
                        y_n      = Y_C;
                        dx_neg_n = 1'b0;
                        cnt_n    = 8'd0;
                    end else if (xs > X_MAX) begin
                        gr_n     = 1'b1;
                        state_n  = PAUSE;
                        x_n      = X_C;
                        y_n      = Y_C;
                        dx_neg_n = 1'b1;
                        cnt_n    = 8'd0;
                    end else begin
                        x_n = xs[10:0];
                        if (ys[11]) begin
                            y_n      = 11'd0;
                            dy_neg_n = 1'b0;
`ifdef BALL_ACCEL_EN
                            if (spd_q < SPD_MAX)
                                spd_n = spd_q + 11'd1;
`endif
                        end else if (ys > Y_MAX) begin
                            y_n      = Y_LIM;
                            dy_neg_n = 1'b1;
`ifdef BALL_ACCEL_EN
                            if (spd_q < SPD_MAX)
                                spd_n = spd_q + 11'd1;
`endif
                        end else begin
                            y_n = ys[10:0];
                        end
                    end
                end
                PAUSE: begin
                    cnt_n = (cnt == 8'hFF) ? cnt
                                           : cnt + 8'd1;
                    if (cnt_n >= P_LIM) begin
                        state_n  = MOVE;
                        cnt_n    = 8'd0;
                        dy_neg_n = 1'b0;
`ifdef BALL_ACCEL_EN
                        spd_n    = SPD0;
`endif
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign ball_x = x;
    assign ball_y = y;

endmodule

// File: rtl/draw_ball.sv
// Pong ball overlay stage after vga_timing: delays timing by one
// cycle and composites the ball over rgb_in.
// Ports: clk, rst (sync, active-high), hcount/vcount/sync/blank
//        and rgb in, start in; delayed timing, rgb_out, ball_x,
//        ball_y, goal_left, goal_right out.
// Optional macro BALL_ACCEL_EN (handled in ball_ctl).
module draw_ball
    import vga_pkg::*;
#(
    parameter int          BALL_SIZE    = 16,
    parameter int          SPEED        = 4,
    parameter int          MAX_SPEED    = 8,
    parameter int          PAUSE_FRAMES = 60,
    parameter logic [11:0] BALL_COLOR   = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        start,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic        goal_left,
    output logic        goal_right
);

    localparam logic [11:0] BS = 12'(BALL_SIZE);

    logic [11:0] hx, vy, bx, by;
    logic        in_ball;

    ball_ctl #(
        .BALL_SIZE   (BALL_SIZE),
        .SPEED       (SPEED),
        .MAX_SPEED   (MAX_SPEED),
        .PAUSE_FRAMES(PAUSE_FRAMES)
    ) u_ctl (
        .clk       (clk),
        .rst       (rst),
        .vblnk_in  (vblnk_in),
        .start     (start),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .goal_left (goal_left),
        .goal_right(goal_right)
    );

    // Widen by one bit so ball_x + BALL_SIZE cannot wrap.
    assign hx = {1'b0, hcount_in};
    assign vy = {1'b0, vcount_in};
    assign bx = {1'b0, ball_x};
    assign by = {1'b0, ball_y};

    assign in_ball = !hblnk_in && !vblnk_in &&
                     hx >= bx && hx < bx + BS &&
                     vy >= by && vy < by + BS;

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out <= 11'd0;
            vcount_out <= 11'd0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= 12'd0;
        end else begin
            hcount_out <= hcount_in;
            vcount_out <= vcount_in;
            hsync_out  <= hsync_in;
            vsync_out  <= vsync_in;
            hblnk_out  <= hblnk_in;
            vblnk_out  <= vblnk_in;
            rgb_out    <= in_ball ? BALL_COLOR : rgb_in;
        end
    end

endmodule

// File: tb/tb_draw_ball.sv
// Self-checking bench for draw_ball: vector table, directed
// serve/bounce/goal/pause sequences and randomized frames.
module tb_draw_ball;

    localparam int BS = 16;
    localparam int SP = 4;
    localparam int MS = 8;
    localparam int PF = 60;
    localparam int XC = 392;
    localparam int YC = 292;
    localparam int XM = 800 - BS;
    localparam int YM = 600 - BS;
`ifdef BALL_ACCEL_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 0, vsync_in = 0;
    logic        hblnk_in = 0, vblnk_in = 0;
    logic [11:0] rgb_in = '0;
    logic        start = 1'b0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [10:0] ball_x, ball_y;
    logic        goal_left, goal_right;

    draw_ball #(
        .BALL_SIZE(BS), .SPEED(SP), .MAX_SPEED(MS),
        .PAUSE_FRAMES(PF), .BALL_COLOR(12'hFFF)
    ) dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .start(start),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .ball_x(ball_x), .ball_y(ball_y),
        .goal_left(goal_left), .goal_right(goal_right)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: 0 idle, 1 moving, 2 paused.
    int m_mode, m_x, m_y, m_dx, m_dy, m_cnt, m_sp, m_serve;
    bit m_start;
    bit pv;
    bit gl_seen, gr_seen;

    task automatic chk(input string nm, input int act,
                       input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    task automatic m_reset();
        m_mode = 0; m_x = XC; m_y = YC;
        m_dx = SP; m_dy = SP; m_cnt = 0; m_sp = SP;
        m_serve = 1; m_start = 0;
    endtask

    function automatic int sgn(input int v);
        return (v < 0) ? -1 : 1;
    endfunction

    task automatic m_tick(output bit gl, output bit gr);
        int xn, yn;
        bit bnc;
        gl = 0; gr = 0; bnc = 0;
        case (m_mode)
            0: if (m_start) begin
                m_mode = 1; m_start = 0;
            end
            1: begin
                xn = m_x + m_dx;
                yn = m_y + m_dy;
                if (xn < 0 || xn > XM) begin
                    if (xn < 0) begin gl = 1; m_serve = 1; end
                    else begin gr = 1; m_serve = -1; end
                    m_x = XC; m_y = YC;
                    m_mode = 2; m_cnt = 0;
                end else begin
                    m_x = xn;
                    if (yn < 0) begin
                        m_y = 0; m_dy = m_sp; bnc = 1;
                    end else if (yn > YM) begin
                        m_y = YM; m_dy = -m_sp; bnc = 1;
                    end else m_y = yn;
                    if (bnc && ACC) begin
                        m_sp = (m_sp + 1 > MS) ? MS : m_sp + 1;
                        m_dx = sgn(m_dx) * m_sp;
                        m_dy = sgn(m_dy) * m_sp;
                    end
                end
            end
            default: begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt >= PF) begin
                    m_mode = 1; m_cnt = 0; m_sp = SP;
                    m_dx = m_serve * SP; m_dy = SP;
                end
            end
        endcase
    endtask

    function automatic int exp_rgb(input int hc, input int vc,
            input bit hb, input bit vb, input int rgb);
        if (!hb && !vb && hc >= m_x && hc < m_x + BS &&
            vc >= m_y && vc < m_y + BS)
            return 'hFFF;
        return rgb;
    endfunction

    // One clock: predict from current inputs, clock, compare all.
    task automatic cyc(input string tag);
        int e_rgb, e_hc, e_vc;
        bit rise, st, gl, gr, was_idle;
        bit e_hs, e_vs, e_hb, e_vb;
        e_hc = int'(hcount_in); e_vc = int'(vcount_in);
        e_hs = hsync_in; e_vs = vsync_in;
        e_hb = hblnk_in; e_vb = vblnk_in;
        e_rgb = exp_rgb(e_hc, e_vc, e_hb, e_vb, int'(rgb_in));
        rise = e_vb && !pv;
        st = start;
        @(posedge clk);
        #1;
        gl = 0; gr = 0;
        if (rst) begin
            m_reset(); pv = 0;
            e_rgb = 0; e_hc = 0; e_vc = 0;
            e_hs = 0; e_vs = 0; e_hb = 0; e_vb = 0;
        end else begin
            pv = e_vb;
            was_idle = (m_mode == 0);
            if (rise) m_tick(gl, gr);
            if (st && was_idle && m_mode == 0) m_start = 1;
        end
        chk({tag, ".rgb"}, int'(rgb_out), e_rgb);
        chk({tag, ".hcnt"}, int'(hcount_out), e_hc);
        chk({tag, ".vcnt"}, int'(vcount_out), e_vc);
        chk({tag, ".sync"},
            int'({hsync_out, vsync_out, hblnk_out, vblnk_out}),
            int'({e_hs, e_vs, e_hb, e_vb}));
        chk({tag, ".gl"}, int'(goal_left), int'(gl));
        chk({tag, ".gr"}, int'(goal_right), int'(gr));
        chk({tag, ".bx"}, int'(ball_x), m_x);
        chk({tag, ".by"}, int'(ball_y), m_y);
    endtask

    task automatic frame(input string tag);
        vblnk_in = 1;
        cyc({tag, ".tick"});
        gl_seen = goal_left;
        gr_seen = goal_right;
        vblnk_in = 0;
        cyc({tag, ".post"});
    endtask

    typedef struct {
        int hc; int vc; bit hb; bit vb; int rgb; int exp;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int hc, vc;
        m_reset();
        pv = 0;

        tbl[0] = '{392, 292, 0, 0, 'h0A0, 'hFFF};
        tbl[1] = '{408, 292, 0, 0, 'h0A0, 'h0A0};
        tbl[2] = '{407, 307, 0, 0, 'h0A0, 'hFFF};
        tbl[3] = '{391, 300, 0, 0, 'h123, 'h123};
        tbl[4] = '{400, 308, 0, 0, 'h456, 'h456};
        tbl[5] = '{392, 292, 1, 0, 'h0A0, 'h0A0};
        tbl[6] = '{392, 292, 0, 1, 'h0A0, 'h0A0};
        tbl[7] = '{400, 300, 0, 0, 'h789, 'hFFF};

        // Reset with non-zero inputs: outputs must be cleared.
        rst = 1;
        hcount_in = 11'd77; vcount_in = 11'd9;
        hsync_in = 1; rgb_in = 12'hABC;
        cyc("rst0");
        cyc("rst1");
        chk("rst.bx", int'(ball_x), 392);
        chk("rst.by", int'(ball_y), 292);
        rst = 0;
        hsync_in = 0;

        // Compositing table with the ball parked at the centre.
        foreach (tbl[i]) begin
            hcount_in = 11'(tbl[i].hc);
            vcount_in = 11'(tbl[i].vc);
            hblnk_in  = tbl[i].hb;
            vblnk_in  = tbl[i].vb;
            rgb_in    = 12'(tbl[i].rgb);
            cyc($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl", i),
                int'(rgb_out), tbl[i].exp);
        end
        vblnk_in = 0; hblnk_in = 0;

        // Serve: first tick does not move, second does.
        start = 1;
        cyc("serve");
        start = 0;
        frame("f0");
        chk("serve.nomove.x", int'(ball_x), 392);
        chk("serve.nomove.y", int'(ball_y), 292);
        frame("f1");
        chk("mt1.x", int'(ball_x), 396);
        chk("mt1.y", int'(ball_y), 296);

        for (int mt = 2; mt <= 99; mt++) begin
            frame($sformatf("mt%0d", mt));
            if (!ACC && mt == 74)
                chk("bottom.y74", int'(ball_y), 584);
            if (!ACC && mt == 75)
                chk("bottom.y75", int'(ball_y), 580);
            if (!ACC && mt == 99) begin
                chk("goal.right", int'(gr_seen), 1);
                chk("goal.cx", int'(ball_x), 392);
                chk("goal.cy", int'(ball_y), 292);
            end
        end

        for (int p = 1; p <= 60; p++) begin
            frame($sformatf("pause%0d", p));
            if (!ACC && (p == 1 || p == 60))
                chk("pause.frozen", int'(ball_x), 392);
        end
        frame("reserve");
        if (!ACC) begin
            chk("reserve.x", int'(ball_x), 388);
            chk("reserve.y", int'(ball_y), 296);
        end
        frame("reserve2");

        // Reset mid-line while moving.
        hcount_in = 11'd500; vcount_in = 11'd120;
        rgb_in = 12'h321;
        rst = 1;
        cyc("midrst");
        chk("midrst.bx", int'(ball_x), 392);
        chk("midrst.by", int'(ball_y), 292);
        rst = 0;
        frame("idle.after.rst");
        chk("idle.hold.x", int'(ball_x), 392);

        // Randomized frames against the model.
        for (int f = 0; f < 320; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                start = 1;
                cyc("rstart");
                start = 0;
            end
            for (int p = 0; p < 3; p++) begin
                hc = m_x + int'($urandom_range(0, 31)) - 8;
                vc = m_y + int'($urandom_range(0, 31)) - 8;
                if (hc < 0) hc = 0;
                if (vc < 0) vc = 0;
                hcount_in = 11'(hc);
                vcount_in = 11'(vc);
                hblnk_in = ($urandom_range(0, 7) == 0);
                hsync_in = 1'($urandom);
                vsync_in = 1'($urandom);
                rgb_in = 12'($urandom);
                cyc("rpix");
            end
            hblnk_in = 0;
            frame("rframe");
            if ($urandom_range(0, 199) == 0) begin
                rst = 1;
                cyc("rrst");
                rst = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
